coalescing_store_buffer: RTL and testbench

//  Speculative, parametrised FIFO between the store unit and the external memory controller.

---
 rtl/store_buffer_pkg.sv | 36 +++
 rtl/store_buffer_forward_unit.sv | 40 ++++
 rtl/coalescing_store_buffer.sv | 158 +++++++++++++++
 tb/tb_coalescing_store_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the coalescing store buffer.
// Module parameters of coalescing_store_buffer default to these values and must stay in step with them,
// because sb_entry_t is sized here.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH      = 8;
  localparam int unsigned SB_ADDR_WIDTH = 32;
  localparam int unsigned SB_DATA_WIDTH = 32;
  localparam int unsigned SB_MAX_MERGE  = 4;

  localparam int unsigned SB_BE_WIDTH  = SB_DATA_WIDTH / 8;
  localparam int unsigned SB_IDX_WIDTH = $clog2(SB_DEPTH);
  localparam int unsigned SB_PTR_WIDTH = SB_IDX_WIDTH + 1;
  localparam int unsigned SB_CNT_WIDTH = $clog2(SB_MAX_MERGE + 1);
  localparam int unsigned SB_OFF_WIDTH = $clog2(SB_BE_WIDTH);

  // Pointer with an extra wrap bit to tell full from empty.
  typedef logic [SB_PTR_WIDTH-1:0] sb_ptr_t;

  typedef struct packed {
    logic                     valid;
    logic                     committed;
    logic [SB_ADDR_WIDTH-1:0] address;
    logic [SB_DATA_WIDTH-1:0] data;
    logic [SB_BE_WIDTH-1:0]   be;
    logic [SB_CNT_WIDTH-1:0]  merge_cnt;
  } sb_entry_t;

  // Clears the byte-offset bits so addresses compare at word granularity.
  function automatic logic [SB_ADDR_WIDTH-1:0] word_align(input logic [SB_ADDR_WIDTH-1:0] addr);
    logic [SB_ADDR_WIDTH-1:0] mask;
    mask = ~((SB_ADDR_WIDTH'(1) << SB_OFF_WIDTH) - SB_ADDR_WIDTH'(1));
    return addr & mask;
  endfunction

endpackage

// File: rtl/store_buffer_forward_unit.sv
// Load forwarding: per byte lane, the youngest valid entry with a matching word address and
// that lane enabled supplies the byte. Entries are scanned oldest-first starting at head,
// so later matches overwrite earlier ones.
module store_buffer_forward_unit
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = SB_DEPTH,
  parameter int unsigned ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SB_DATA_WIDTH
) (
  input  sb_entry_t                 entries_i [DEPTH],
  input  logic [SB_IDX_WIDTH-1:0]   head_idx_i,
  input  logic [ADDR_WIDTH-1:0]     fwd_address_i,
  input  logic [DATA_WIDTH/8-1:0]   fwd_be_i,
  output logic [DATA_WIDTH-1:0]     fwd_data_o,
  output logic [DATA_WIDTH/8-1:0]   covered_o
);

  // Age-ordered priority select, youngest match per lane wins.
  always_comb begin
    logic [SB_IDX_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0]   faddr;
    fwd_data_o = '0;
    covered_o  = '0;
    idx        = '0;
    faddr      = word_align(fwd_address_i);
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_idx_i + SB_IDX_WIDTH'(k);
      if (entries_i[idx].valid && (entries_i[idx].address == faddr)) begin
        for (int unsigned l = 0; l < DATA_WIDTH / 8; l++) begin
          if (entries_i[idx].be[l] && fwd_be_i[l]) begin
            fwd_data_o[8*l +: 8] = entries_i[idx].data[8*l +: 8];
            covered_o[l]         = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/coalescing_store_buffer.sv
// Speculative store buffer: coalesces stores into the youngest uncommitted entry, drains
// only committed entries to memory, discards uncommitted ones on flush, forwards to loads.
module coalescing_store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = SB_DEPTH,
  parameter int unsigned ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SB_DATA_WIDTH,
  parameter int unsigned MAX_MERGE  = SB_MAX_MERGE
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    flush_i,
  input  logic                    push_valid_i,
  output logic                    push_ready_o,
  input  logic [ADDR_WIDTH-1:0]   push_address_i,
  input  logic [DATA_WIDTH-1:0]   push_data_i,
  input  logic [DATA_WIDTH/8-1:0] push_be_i,
  input  logic                    commit_i,
  output logic                    pull_valid_o,
  input  logic                    pull_ready_i,
  output logic [ADDR_WIDTH-1:0]   pull_address_o,
  output logic [DATA_WIDTH-1:0]   pull_data_o,
  output logic [DATA_WIDTH/8-1:0] pull_be_o,
  input  logic [ADDR_WIDTH-1:0]   fwd_address_i,
  input  logic [DATA_WIDTH/8-1:0] fwd_be_i,
  output logic [DATA_WIDTH-1:0]   fwd_data_o,
  output logic                    fwd_hit_o,
  output logic                    fwd_partial_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned IW = SB_IDX_WIDTH;
  localparam int unsigned CW = SB_CNT_WIDTH;

  sb_entry_t     entries_q [DEPTH];
  logic [CW-1:0] pend_q    [DEPTH];   // stores in the entry still awaiting commit_i
  sb_ptr_t       head_q, commit_q, tail_q;

  sb_ptr_t                 young_ptr;
  logic [IW-1:0]           head_idx, commit_idx, tail_idx, young_idx;
  logic [ADDR_WIDTH-1:0]   push_word;
  logic [DATA_WIDTH-1:0]   push_mask;
  logic [DATA_WIDTH/8-1:0] covered;
  logic merge_cond, push_fire, do_merge, do_alloc;
  logic do_commit, merge_on_commit, same_entry, commit_adv, pull_fire;

  assign young_ptr  = tail_q - sb_ptr_t'(1);
  assign head_idx   = head_q[IW-1:0];
  assign commit_idx = commit_q[IW-1:0];
  assign tail_idx   = tail_q[IW-1:0];
  assign young_idx  = young_ptr[IW-1:0];
  assign push_word  = word_align(push_address_i);

  assign full_o  = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);
  assign empty_o = (head_q == tail_q);

  // Expand byte enables to a bit mask for lane-wise merging.
  always_comb begin
    push_mask = '0;
    for (int unsigned l = 0; l < DATA_WIDTH / 8; l++) begin
      push_mask[8*l +: 8] = {8{push_be_i[l]}};
    end
  end

  assign merge_cond = push_valid_i && !flush_i &&
                      entries_q[young_idx].valid && !entries_q[young_idx].committed &&
                      (entries_q[young_idx].address == push_word) &&
                      (entries_q[young_idx].merge_cnt < CW'(MAX_MERGE));

  assign push_ready_o = !flush_i && (!full_o || merge_cond);
  assign push_fire    = push_valid_i && push_ready_o;
  assign do_merge     = push_fire && merge_cond;
  assign do_alloc     = push_fire && !merge_cond;

  // A commit and a merge landing on the same entry cancel in the pending count, so the
  // freshly merged store stays speculative and the entry does not commit this cycle.
  assign do_commit       = commit_i && (commit_q != tail_q);
  assign merge_on_commit = do_merge && (young_idx == commit_idx);
  assign same_entry      = do_commit && merge_on_commit;
  assign commit_adv      = do_commit && (pend_q[commit_idx] == CW'(1)) && !merge_on_commit;

  assign pull_valid_o   = (head_q != commit_q);
  assign pull_fire      = pull_valid_o && pull_ready_i;
  assign pull_address_o = entries_q[head_idx].address;
  assign pull_data_o    = entries_q[head_idx].data;
  assign pull_be_o      = entries_q[head_idx].be;

  // Pointer and entry state update: pull, commit, merge/allocate, then flush.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
        pend_q[i]    <= '0;
      end
    end else begin
      if (pull_fire) begin
        entries_q[head_idx].valid <= 1'b0;
        head_q                    <= head_q + sb_ptr_t'(1);
      end
      if (do_commit && !same_entry) begin
        pend_q[commit_idx] <= pend_q[commit_idx] - CW'(1);
      end
      if (commit_adv) begin
        entries_q[commit_idx].committed <= 1'b1;
      end
      commit_q <= commit_q + sb_ptr_t'(commit_adv);
      if (do_merge) begin
        entries_q[young_idx].data      <= (entries_q[young_idx].data & ~push_mask) |
                                          (push_data_i & push_mask);
        entries_q[young_idx].be        <= entries_q[young_idx].be | push_be_i;
        entries_q[young_idx].merge_cnt <= entries_q[young_idx].merge_cnt + CW'(1);
        if (!same_entry) begin
          pend_q[young_idx] <= pend_q[young_idx] + CW'(1);
        end
      end
      if (do_alloc) begin
        entries_q[tail_idx] <= '{valid:     1'b1,
                                 committed: 1'b0,
                                 address:   push_word,
                                 data:      push_data_i & push_mask,
                                 be:        push_be_i,
                                 merge_cnt: CW'(1)};
        pend_q[tail_idx]    <= CW'(1);
        tail_q              <= tail_q + sb_ptr_t'(1);
      end
      if (flush_i) begin
        tail_q <= commit_q + sb_ptr_t'(commit_adv);
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (!entries_q[i].committed && !(commit_adv && (IW'(i) == commit_idx))) begin
            entries_q[i].valid <= 1'b0;
          end
        end
      end
    end
  end

  store_buffer_forward_unit #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fwd (
    .entries_i     (entries_q),
    .head_idx_i    (head_idx),
    .fwd_address_i (fwd_address_i),
    .fwd_be_i      (fwd_be_i),
    .fwd_data_o    (fwd_data_o),
    .covered_o     (covered)
  );

  assign fwd_hit_o     = (covered == fwd_be_i) && (fwd_be_i != '0);
  assign fwd_partial_o = (covered != '0) && !fwd_hit_o;

endmodule

// File: tb/tb_coalescing_store_buffer.sv
// Bench for coalescing_store_buffer: directed scenarios plus randomized traffic against a
// queue-based reference model; drained entries are checked by an independent monitor.
module tb_coalescing_store_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned MAXM  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, push_valid, push_ready, commit, pull_valid, pull_ready;
  logic [31:0] push_address, push_data, pull_address, pull_data, fwd_address, fwd_data;
  logic [3:0]  push_be, pull_be, fwd_be;
  logic        fwd_hit, fwd_partial, full, empty;

  always #5 clk = ~clk;

  coalescing_store_buffer #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MAX_MERGE  (MAXM)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .flush_i        (flush),
    .push_valid_i   (push_valid),
    .push_ready_o   (push_ready),
    .push_address_i (push_address),
    .push_data_i    (push_data),
    .push_be_i      (push_be),
    .commit_i       (commit),
    .pull_valid_o   (pull_valid),
    .pull_ready_i   (pull_ready),
    .pull_address_o (pull_address),
    .pull_data_o    (pull_data),
    .pull_be_o      (pull_be),
    .fwd_address_i  (fwd_address),
    .fwd_be_i       (fwd_be),
    .fwd_data_o     (fwd_data),
    .fwd_hit_o      (fwd_hit),
    .fwd_partial_o  (fwd_partial),
    .full_o         (full),
    .empty_o        (empty)
  );

  // Reference model: a queue of word entries, the first ncom of which are committed.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int unsigned total;
    int unsigned remain;
  } ment_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } pull_t;

  ment_t       mq[$];
  int unsigned ncom = 0;
  pull_t       exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{be[l]}};
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pull must match the oldest entry the model has committed.
  always @(negedge clk) begin
    pull_t e;
    if (rst_n === 1'b1 && pull_valid === 1'b1 && pull_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pull_unexpected: got addr %h, expected no pull", pull_address);
      end else begin
        e = exp_q.pop_front();
        chk("pull_addr", pull_address, e.addr);
        chk("pull_be", {28'd0, pull_be}, {28'd0, e.be});
        chk("pull_data", pull_data & lane_mask(e.be), e.data & lane_mask(e.be));
      end
    end
  end

  task automatic chk_reset_values();
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_push_ready", {31'd0, push_ready}, 32'd1);
    chk("rst_pull_valid", {31'd0, pull_valid}, 32'd0);
    chk("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);
    chk("rst_fwd_partial", {31'd0, fwd_partial}, 32'd0);
    chk("rst_pull_addr", pull_address, 32'd0);
    chk("rst_pull_data", pull_data, 32'd0);
    chk("rst_pull_be", {28'd0, pull_be}, 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
  endtask

  // One clock cycle: drive, check combinational outputs against the model, then advance the model.
  task automatic step(input logic pv, input logic [31:0] pa, input logic [31:0] pd,
                      input logic [3:0] pb, input logic cm, input logic fl, input logic pr,
                      input logic [31:0] fa, input logic [3:0] fb);
    logic [31:0] wa, fw, fdata, m;
    logic [3:0]  cov;
    bit          merge_ok, ready, hit, do_push, do_commit, do_pull;
    ment_t       t;
    push_valid = pv; push_address = pa; push_data = pd; push_be = pb;
    commit = cm; flush = fl; pull_ready = pr; fwd_address = fa; fwd_be = fb;
    @(negedge clk);
    wa = pa & ~32'h3;
    m  = lane_mask(pb);
    merge_ok = pv && !fl && (mq.size() > ncom) &&
               (mq[mq.size()-1].addr == wa) && (mq[mq.size()-1].total < MAXM);
    ready = !fl && ((mq.size() < DEPTH) || merge_ok);
    chk("push_ready", {31'd0, push_ready}, {31'd0, ready});
    chk("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
    chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
    chk("pull_valid", {31'd0, pull_valid}, {31'd0, ncom > 0});
    fw = fa & ~32'h3; fdata = '0; cov = '0;
    foreach (mq[i]) begin
      if (mq[i].addr == fw) begin
        for (int l = 0; l < 4; l++) begin
          if (mq[i].be[l] && fb[l]) begin
            fdata[8*l +: 8] = mq[i].data[8*l +: 8];
            cov[l] = 1'b1;
          end
        end
      end
    end
    hit = (cov == fb) && (fb != 4'd0);
    chk("fwd_hit", {31'd0, fwd_hit}, {31'd0, hit});
    chk("fwd_partial", {31'd0, fwd_partial}, {31'd0, (cov != 4'd0) && !hit});
    chk("fwd_data", fwd_data & lane_mask(fb), fdata);
    do_push   = pv && ready;
    do_commit = cm && (mq.size() > ncom);
    do_pull   = (ncom > 0) && pr;
    @(posedge clk);
    #1;
    if (do_commit) begin
      t = mq[ncom]; t.remain--; mq[ncom] = t;
    end
    if (do_push) begin
      if (merge_ok) begin
        t = mq[mq.size()-1];
        t.data = (t.data & ~m) | (pd & m);
        t.be   = t.be | pb;
        t.total++;
        t.remain++;
        mq[mq.size()-1] = t;
      end else begin
        t = '{wa, pd & m, pb, 1, 1};
        mq.push_back(t);
      end
    end
    if (do_commit && mq[ncom].remain == 0) begin
      exp_q.push_back('{mq[ncom].addr, mq[ncom].data, mq[ncom].be});
      ncom++;
    end
    if (fl) begin
      while (mq.size() > ncom) void'(mq.pop_back());
    end
    if (do_pull) begin
      void'(mq.pop_front());
      ncom--;
    end
  endtask

  task automatic idle(input logic cm, input logic pr, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, cm, 0, pr, 0, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h100 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    rst_n = 1'b0;
    push_valid = 0; push_address = 0; push_data = 0; push_be = 0; commit = 0;
    flush = 0; pull_ready = 0; fwd_address = 0; fwd_be = 0;
    #2;
    chk_reset_values();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single store, commit, drain.
    step(1, 32'h100, 32'h11223344, 4'hF, 0, 0, 0, 32'h100, 4'hF);
    step(0, 0, 0, 0, 1, 0, 0, 32'h100, 4'h3);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(0, 0, 1);

    // Two stores coalesce into one entry needing two commits.
    step(1, 32'h200, 32'h000000AA, 4'h1, 0, 0, 0, 0, 0);
    step(1, 32'h201, 32'h00BB0000, 4'h4, 0, 0, 0, 32'h200, 4'h5);
    step(0, 0, 0, 0, 1, 0, 1, 32'h200, 4'h7);
    step(0, 0, 0, 0, 1, 0, 1, 0, 0);
    idle(0, 1, 2);

    // Fill to full; a new address is refused, the youngest address still merges.
    for (int i = 0; i < 8; i++) step(1, 32'h1000 + 32'(16 * i), $urandom, 4'hF, 0, 0, 0, 0, 0);
    step(1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 0, 1, 0, 0);
    step(1, 32'h1070, 32'h0000CC00, 4'h2, 0, 0, 1, 32'h1070, 4'hF);
    idle(1, 1, 12);

    // Flush discards uncommitted entries, the committed one drains.
    step(1, 32'h400, 32'h01010101, 4'hF, 0, 0, 0, 0, 0);
    step(1, 32'h404, 32'h02020202, 4'hF, 0, 0, 0, 0, 0);
    step(1, 32'h408, 32'h03030303, 4'hF, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'h404, 4'hF);
    step(0, 0, 0, 0, 0, 0, 0, 32'h404, 4'hF);
    step(0, 0, 0, 0, 0, 0, 1, 32'h408, 4'h1);
    idle(0, 1, 2);

    // Overlapping entries: partial vs full coverage, youngest lanes win.
    step(1, 32'h300, 32'h00001122, 4'h3, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 32'h300, 32'h00AABB00, 4'h6, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 32'h300, 4'hF);
    step(0, 0, 0, 0, 0, 0, 0, 32'h302, 4'h6);
    step(0, 0, 0, 0, 0, 0, 0, 32'h300, 4'h3);
    idle(1, 1, 4);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 5; i++) step(1, 32'h500 + 32'(4 * i), $urandom, 4'hF, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    push_valid = 0; commit = 0; flush = 0; pull_ready = 0; fwd_address = 32'h504; fwd_be = 4'h0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_values();
    mq.delete(); exp_q.delete(); ncom = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 6, rand_addr(), $urandom, 4'($urandom),
           $urandom_range(0, 9) < 4, $urandom_range(0, 24) == 0, 1'($urandom),
           rand_addr(), 4'($urandom));
    end
    idle(1, 1, DEPTH * MAXM + 8);
    chk("drain_exp_q_size", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
